// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared 720x480p60 raster constants for the timing and pixel stages
//
// Purpose: single source of the default raster geometry, the coordinate widths
// shared with the pixel stage, and the pixel-stage window offsets used to place
// the 512x384 scaled image inside the 720x480 active area.
// Ports: none (package).

package video_timing_pkg;

  // Horizontal geometry, in pixels; the line runs active, front porch, sync, back porch.
  localparam int H_ACTIVE_DEF = 720;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 62;
  localparam int H_BP_DEF     = 60;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical geometry, in lines; same ordering as horizontal.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 9;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 30;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Coordinate widths shared by the timing generator and the pixel stage.
  localparam int VIDEO_X_BITWIDTH = 10;
  localparam int VIDEO_Y_BITWIDTH = 10;

  // Top-left corner of the 512x384 window inside the 720x480 active area.
  localparam int PIX_WIN_X_OFFSET = 104;
  localparam int PIX_WIN_Y_OFFSET = 48;

endpackage

// File: rtl/sig_delay_line.sv
// rtl/sig_delay_line.sv - ce-gated shift register delaying a bus by DEPTH cycles
//
// Purpose: aligns control signals with a downstream pipeline of fixed latency.
// DEPTH=0 is a plain wire; otherwise every stage resets to RESET_VAL.
// Ports:
//   clk  in            clock, all logic on posedge
//   rst  in            synchronous active-low reset
//   ce   in            stage enable; stages hold while ce=0
//   d    in  [WIDTH]   input bus
//   q    out [WIDTH]   d delayed by DEPTH ce-cycles

module sig_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator feeding the pixel stage and frame buffer
//
// Purpose: free-running x/y raster counters with line/frame strobes, plus
// hsync/vsync/de delayed to match the pixel stage's RGB pipeline latency.
// The raster phase (active, front porch, sync, back porch) is implied by x/y.
// Ports:
//   clk          in        pixel clock
//   rst          in        synchronous active-low reset
//   ce           in        pixel enable; everything holds while ce=0
//   x            out [XW]  horizontal count, undelayed
//   y            out [YW]  vertical count, undelayed
//   hsync        out       delayed horizontal sync
//   vsync        out       delayed vertical sync (line aligned)
//   de           out       delayed data enable (active area)
//   line_start   out       pulse while x=0 after a wrap, undelayed
//   frame_start  out       pulse while x=0,y=0 after a wrap, undelayed
//   frame_cnt    out [8]   frame counter, wraps 255->0

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE         = H_ACTIVE_DEF,
  parameter int H_FP             = H_FP_DEF,
  parameter int H_SYNC           = H_SYNC_DEF,
  parameter int H_BP             = H_BP_DEF,
  parameter int V_ACTIVE         = V_ACTIVE_DEF,
  parameter int V_FP             = V_FP_DEF,
  parameter int V_SYNC           = V_SYNC_DEF,
  parameter int V_BP             = V_BP_DEF,
  parameter int SYNC_ACTIVE_LOW  = 1,
  parameter int SYNC_DELAY       = 2,
  parameter int VIDEO_X_BITWIDTH = video_timing_pkg::VIDEO_X_BITWIDTH,
  parameter int VIDEO_Y_BITWIDTH = video_timing_pkg::VIDEO_Y_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  output logic [VIDEO_X_BITWIDTH-1:0] x,
  output logic [VIDEO_Y_BITWIDTH-1:0] y,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [7:0]                  frame_cnt
);

  localparam int XW      = VIDEO_X_BITWIDTH;
  localparam int YW      = VIDEO_Y_BITWIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << XW)) begin : g_bad_x_width
    $error("video_timing_gen: H_TOTAL does not fit in VIDEO_X_BITWIDTH");
  end
  if (V_TOTAL > (1 << YW)) begin : g_bad_y_width
    $error("video_timing_gen: V_TOTAL does not fit in VIDEO_Y_BITWIDTH");
  end

  // Compare on one extra bit so a boundary equal to 2^width still fits.
  localparam logic [XW:0] H_LAST   = (XW+1)'(H_TOTAL - 1);
  localparam logic [XW:0] H_ACT    = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_BEGIN = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END   = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] V_LAST   = (YW+1)'(V_TOTAL - 1);
  localparam logic [YW:0] V_ACT    = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_BEGIN = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END   = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_POL = (SYNC_ACTIVE_LOW != 0);

  logic [XW:0] x_ext;
  logic [YW:0] y_ext;
  logic        h_wrap;
  logic        v_wrap;
  logic        de_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic [2:0]  ctl_raw;
  logic [2:0]  ctl_dly;

  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign h_wrap = (x_ext == H_LAST);
  assign v_wrap = (y_ext == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      // Strobes are registered alongside the wrap so they coincide with x=0.
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap) begin
        x <= '0;
        if (v_wrap) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // vs_raw only looks at y, so vsync changes on the line boundary.
  assign de_raw  = (x_ext < H_ACT) && (y_ext < V_ACT);
  assign hs_raw  = (x_ext >= HS_BEGIN) && (x_ext < HS_END);
  assign vs_raw  = (y_ext >= VS_BEGIN) && (y_ext < VS_END);
  assign ctl_raw = {de_raw, hs_raw ^ SYNC_POL, vs_raw ^ SYNC_POL};

  sig_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL ({1'b0, SYNC_POL, SYNC_POL})
  ) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (ctl_raw),
    .q   (ctl_dly)
  );

  assign {de, hsync, vsync} = ctl_dly;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel generator.
- Produces raw pixel coordinates (x, y) for 720x480p60 at a 27 MHz pixel rate, consumed by the pixel stage, which windows and scales them to 512x384.
- Also produces hsync, vsync and data-enable, delayed so they line up with the pixel stage's RGB pipeline latency.
- Drives frame and line strobes for the frame-buffer write side.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 62, hsync width in pixels
- H_BP, 60, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 9, vertical front porch in lines
- V_SYNC, 6, vsync width in lines
- V_BP, 30, vertical back porch in lines
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
- SYNC_DELAY, 2, pipeline stages applied to hsync/vsync/de (matches the downstream RAM read plus the registered RGB stage)
- VIDEO_X_BITWIDTH, 10, width of x
- VIDEO_Y_BITWIDTH, 10, width of y

Ports:
- clk  in  1  pixel clock. One clock domain; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-low
- ce  in  1  pixel enable. Counters advance only when ce=1.
- x  out  VIDEO_X_BITWIDTH  horizontal count 0..857, undelayed
- y  out  VIDEO_Y_BITWIDTH  vertical count 0..524, undelayed
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- de  out  1  delayed data enable (active area)
- line_start  out  1  one-cycle pulse when x wraps to 0, undelayed
- frame_start  out  1  one-cycle pulse when x=0 and y=0, undelayed
- frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 858; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Line layout: active region first, then front porch, sync, back porch.
  - Horizontal: active x = 0..719; hsync region x = 736..797.
  - Vertical: active y = 0..479; vsync region y = 489..494.
- Reset (rst=0 at a clock edge):
  - x=0, y=0, frame_cnt=0, line_start=0, frame_start=0.
  - All delay stages are loaded with the idle value: de=0, sync deasserted (1 when SYNC_ACTIVE_LOW).
  - Reset overrides ce. Reset mid-frame restarts at (0,0) on the next edge, with no partial-line pulse.
- Counting (ce=1, rst=1):
  - x increments each cycle. At x = H_TOTAL-1, x wraps to 0 and y increments.
  - At y = V_TOTAL-1 with x wrapping, y wraps to 0 and frame_cnt increments mod 256.
  - ce=0 holds all counters, pulses and delay stages; the pipeline is gated by ce as well.
- line_start and frame_start are registered and asserted in the cycle where the registered x=0 (and y=0 for frame_start).
  - The first cycle after reset release does not pulse; the first pulses come at the first wrap.
  - frame_start implies line_start.
- Raw combinational terms, computed from the registered counters:
  - de_raw = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs_raw = (x >= H_ACTIVE+H_FP) && (x < H_ACTIVE+H_FP+H_SYNC)
  - vs_raw similar on y; vsync is line-aligned (it changes at x=0).
- Output polarity: hsync = hs_raw XOR SYNC_ACTIVE_LOW after delay; vsync likewise.
- Delay: de/hsync/vsync reach the outputs exactly SYNC_DELAY ce-cycles after the x/y values that produced them.
  - SYNC_DELAY=0 means combinational pass-through from the registered counters.
- Widths: comparisons use widths wide enough for H_TOTAL/V_TOTAL. Elaboration fails if H_TOTAL > 2^VIDEO_X_BITWIDTH or V_TOTAL > 2^VIDEO_Y_BITWIDTH.
- States (implicit in y): ACTIVE, V_FRONT, V_SYNC, V_BACK. No separate FSM register; the phase is fully determined by the counters.

Decomposition:
- Shared package video_timing_pkg:
  - 720x480p60 default constants (active, porch and sync values, H_TOTAL, V_TOTAL)
  - VIDEO_X_BITWIDTH and VIDEO_Y_BITWIDTH, used by both this block and the pixel stage
  - the pixel-stage window offsets 104/48
- One sub-module: sig_delay_line.
  - Parameters: WIDTH, DEPTH, RESET_VAL.
  - Ports: clk, rst (sync active-low), ce, d, q.
  - Used once here with WIDTH=3 for {de, hsync, vsync}.

Test Plan:
- Reset held 5 cycles, then released with ce=1 -> x=0, y=0, de=0, hsync=vsync=1 during reset; x=1 one cycle after release; first line_start when x wraps 857->0 (cycle 858 after release).
- Free-run one full frame of 858*525 = 450450 cycles -> exactly 525 line_start pulses and 1 frame_start; frame_cnt 0->1; de high for 720*480 = 345600 cycles.
- Sync position with SYNC_DELAY=2 -> hsync low for 62 cycles per line, first low at the output when raw x=738 (delayed from 736); vsync low across y=489..494 plus 2 cycles of skew; de rises 2 cycles after x=0 on y=0.
- ce toggled 1,0,1,0 -> x advances only on ce=1 cycles; outputs and pulses frozen while ce=0; frame length counted in ce cycles is still 450450.
- Reset asserted at x=400, y=300 -> next edge x=0, y=0, de=0, no line_start in that cycle; frame_cnt=0.
- Run 256 frames (fast via small parameter overrides: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1) -> frame_cnt wraps 255->0 with frame_start asserted in the same cycle.
